// File: rtl/sbox4_dom_pkg.sv
// GF(2^2)/GF(16) helpers and basis/affine matrices for the masked 4-bit S-box.
// GF(2^2) is polynomial in W (W^2=W+1); GF(16) normal basis is {Y^4, Y} over GF(2^2), nu=W.
package sbox4_dom_pkg;

  typedef logic [1:0] gf4_t;
  typedef logic [3:0] nib_t;
  typedef struct packed {
    gf4_t h;
    gf4_t l;
  } tower_t;

  // Row r of each matrix is the mask of input bits XORed into output bit r.
  localparam logic [3:0][3:0] POLY2NORM = {4'b1100, 4'b0001, 4'b0100, 4'b1111};
  localparam logic [3:0][3:0] NORM2POLY = {4'b1010, 4'b0010, 4'b1101, 4'b0100};
  localparam logic [3:0][3:0] AFFINE    = {4'b1011, 4'b1101, 4'b1110, 4'b0111};
  localparam nib_t            AFFINE_C  = 4'h6;

  function automatic int rnd_w(input int shares);
    return 3 * shares * (shares - 1);
  endfunction

  // Position of the unordered share pair (i<j) in ascending (i,j) order.
  function automatic int pair_idx(input int i, input int j, input int shares);
    return i * shares - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  function automatic nib_t mat_apply(input logic [3:0][3:0] m, input nib_t x);
    nib_t y;
    for (int r = 0; r < 4; r++) y[r] = ^(m[r] & x);
    return y;
  endfunction

  function automatic gf4_t gf2_mul(input gf4_t a, input gf4_t b);
    return {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]),
            (a[1] & b[1]) ^ (a[0] & b[0])};
  endfunction

  // nu * x^2 with nu = W collapses to a bit swap in this representation.
  function automatic gf4_t gf2_sq_scale(input gf4_t a);
    return {a[0], a[1]};
  endfunction

  // x^-1 = x^2 in GF(4), which also maps 0 to 0.
  function automatic gf4_t gf2_inv(input gf4_t a);
    return {a[1], a[1] ^ a[0]};
  endfunction

endpackage

// File: rtl/dom_mul_gf4.sv
// DOM-indep GF(2^2) multiplier over SHARES shares; inner and cross terms registered on en.
// Latency 1 cycle (compression is combinational after the register); en=0 holds every term.
module dom_mul_gf4
  import sbox4_dom_pkg::*;
#(
  parameter int SHARES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [2*SHARES-1:0]          a,
  input  logic [2*SHARES-1:0]          b,
  input  logic [SHARES*(SHARES-1)-1:0] z,
  output logic [2*SHARES-1:0]          c
);

  localparam int NX = SHARES * (SHARES - 1);

  gf4_t inner_q [SHARES];
  gf4_t cross_q [NX];

  // Cross term (i,j), j!=i, stored densely without the diagonal.
  function automatic int xidx(input int i, input int j);
    return i * (SHARES - 1) + ((j < i) ? j : j - 1);
  endfunction

  // Both orientations of a pair share the same fresh mask.
  function automatic int zidx(input int i, input int j);
    return (i < j) ? pair_idx(i, j, SHARES) : pair_idx(j, i, SHARES);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SHARES; i++) inner_q[i] <= '0;
      for (int k = 0; k < NX; k++) cross_q[k] <= '0;
    end else if (en) begin
      for (int i = 0; i < SHARES; i++) begin
        inner_q[i] <= gf2_mul(a[2*i +: 2], b[2*i +: 2]);
        for (int j = 0; j < SHARES; j++) begin
          if (j != i)
            cross_q[xidx(i, j)] <= gf2_mul(a[2*i +: 2], b[2*j +: 2]) ^ z[2*zidx(i, j) +: 2];
        end
      end
    end
  end

  always_comb begin
    c = '0;
    for (int i = 0; i < SHARES; i++) begin
      c[2*i +: 2] = inner_q[i];
      for (int j = 0; j < SHARES; j++) begin
        if (j != i) c[2*i +: 2] = c[2*i +: 2] ^ cross_q[xidx(i, j)];
      end
    end
  end

endmodule

// File: rtl/dom_sbox4_pipe.sv
// Masked SR(.,.,.,4) S-box, d+1 DOM shares, tower-field inversion; SSAES_AFFINE_EN adds the affine layer.
// Latency 2 cycles from input fire to out_valid, one beat per cycle at full throughput.
// Elastic valid/ready: a stage advances only into an empty or draining successor; stalls hold all state.
module dom_sbox4_pipe
  import sbox4_dom_pkg::*;
#(
  parameter int SHARES = 2,
  parameter int RND_W  = rnd_w(SHARES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*SHARES-1:0]   in_shares,
  input  logic [RND_W-1:0]      rnd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*SHARES-1:0]   out_shares
);

  localparam int MR = RND_W / 3;

  logic v1, v2, adv1, adv2;
  logic [2*SHARES-1:0] h0_s, l0_s, sq0_s;
  logic [2*SHARES-1:0] h1_q, l1_q, sq1_q;
  logic [2*MR-1:0]     rnd2_q;
  logic [2*SHARES-1:0] hl_s, tinv_s, ohi_s, olo_s;

  assign in_ready  = !v1 || !v2 || out_ready;
  assign adv1      = in_valid && in_ready;
  assign adv2      = v1 && (!v2 || out_ready);
  assign out_valid = v2;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (adv1)      v1 <= 1'b1;
      else if (adv2) v1 <= 1'b0;
      if (adv2)           v2 <= 1'b1;
      else if (out_ready) v2 <= 1'b0;
    end
  end

  always_comb begin
    tower_t n;
    h0_s  = '0;
    l0_s  = '0;
    sq0_s = '0;
    for (int i = 0; i < SHARES; i++) begin
      n = tower_t'(mat_apply(POLY2NORM, in_shares[4*i +: 4]));
      h0_s[2*i +: 2]  = n.h;
      l0_s[2*i +: 2]  = n.l;
      sq0_s[2*i +: 2] = gf2_sq_scale(n.h ^ n.l);
    end
  end

  dom_mul_gf4 #(.SHARES(SHARES)) u_mul_hl (
    .clk (clk),
    .rst (rst),
    .en  (adv1),
    .a   (h0_s),
    .b   (l0_s),
    .z   (rnd[0 +: MR]),
    .c   (hl_s)
  );

  // Linear terms and the stage-2 masks travel with the beat through stage 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      h1_q   <= '0;
      l1_q   <= '0;
      sq1_q  <= '0;
      rnd2_q <= '0;
    end else if (adv1) begin
      h1_q   <= h0_s;
      l1_q   <= l0_s;
      sq1_q  <= sq0_s;
      rnd2_q <= rnd[MR +: 2*MR];
    end
  end

  always_comb begin
    tinv_s = '0;
    for (int i = 0; i < SHARES; i++)
      tinv_s[2*i +: 2] = gf2_inv(hl_s[2*i +: 2] ^ sq1_q[2*i +: 2]);
  end

  dom_mul_gf4 #(.SHARES(SHARES)) u_mul_hi (
    .clk (clk),
    .rst (rst),
    .en  (adv2),
    .a   (tinv_s),
    .b   (l1_q),
    .z   (rnd2_q[0 +: MR]),
    .c   (ohi_s)
  );

  dom_mul_gf4 #(.SHARES(SHARES)) u_mul_lo (
    .clk (clk),
    .rst (rst),
    .en  (adv2),
    .a   (tinv_s),
    .b   (h1_q),
    .z   (rnd2_q[MR +: MR]),
    .c   (olo_s)
  );

  // Constant goes into share 0 only, and only for a valid beat so idle output stays zero.
  always_comb begin
    nib_t p;
    out_shares = '0;
    for (int i = 0; i < SHARES; i++) begin
      p = mat_apply(NORM2POLY, {ohi_s[2*i +: 2], olo_s[2*i +: 2]});
`ifdef SSAES_AFFINE_EN
      p = mat_apply(AFFINE, p) ^ ((i == 0 && v2) ? AFFINE_C : 4'h0);
`endif
      out_shares[4*i +: 4] = p;
    end
  end

endmodule

// File: tb/tb_dom_sbox4_pipe.sv
// Randomized bench for dom_sbox4_pipe: scoreboard against a GF(16) brute-force inverse / S-box table.
module tb_dom_sbox4_pipe;

  parameter int SHARES = 3;
  localparam int RND_W = 3 * SHARES * (SHARES - 1);

  logic                clk = 1'b0;
  logic                rst, in_valid, in_ready, out_valid, out_ready;
  logic [4*SHARES-1:0] in_shares, out_shares;
  logic [RND_W-1:0]    rnd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dom_sbox4_pipe #(.SHARES(SHARES)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_shares  (in_shares),
    .rnd        (rnd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_shares (out_shares)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r, x;
    r = 4'h0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r ^= x;
      x = {x[2:0], 1'b0} ^ (x[3] ? 4'b0011 : 4'b0000);
    end
    return r;
  endfunction

  function automatic logic [3:0] gf16_inv(input logic [3:0] a);
    logic [3:0] r;
    r = 4'h0;
    for (int b = 1; b < 16; b++)
      if (gf16_mul(a, 4'(b)) == 4'h1) r = 4'(b);
    return r;
  endfunction

  function automatic logic [3:0] ref_sbox(input logic [3:0] x);
`ifdef SSAES_AFFINE_EN
    logic [63:0] tab;
    tab = 64'h6B54_2E7A_9DFC_3108;
    return tab[4*(15 - int'(x)) +: 4];
`else
    return gf16_inv(x);
`endif
  endfunction

  function automatic logic [3:0] recomb(input logic [4*SHARES-1:0] v);
    logic [3:0] s;
    s = 4'h0;
    for (int i = 0; i < SHARES; i++) s ^= v[4*i +: 4];
    return s;
  endfunction

  // Scoreboard: expected results and fire cycles, in acceptance order.
  logic [3:0]          exp_q[$];
  int                  fire_q[$];
  int                  cyc = 0, n_out = 0, n_in = 0;
  bit                  lat_chk = 1'b0;
  bit                  held = 1'b0;
  logic [4*SHARES-1:0] held_dat;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      fire_q.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_shares), 32'(held_dat));
      end
      held     = out_valid && !out_ready;
      held_dat = out_shares;
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          logic [3:0] e;
          int fc;
          e  = exp_q.pop_front();
          fc = fire_q.pop_front();
          chk("sbox", 32'(recomb(out_shares)), 32'(e));
          if (lat_chk) chk("latency", 32'(cyc - fc), 32'd2);
        end
      end
      if (in_valid && in_ready) begin
        n_in++;
        exp_q.push_back(ref_sbox(recomb(in_shares)));
        fire_q.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [3:0] s);
    logic [4*SHARES-1:0] sh;
    logic [3:0]          acc;
    bit                  took;
    int                  tries;
    acc = s;
    sh  = '0;
    for (int i = 1; i < SHARES; i++) begin
      sh[4*i +: 4] = 4'($urandom);
      acc ^= sh[4*i +: 4];
    end
    sh[3:0]   = acc;
    in_shares = sh;
    rnd       = RND_W'({$urandom, $urandom});
    in_valid  = 1'b1;
    tries     = 0;
    took      = 1'b0;
    while (!took && tries < 50) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    if (!took) chk("accept_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, c0, i0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_shares = '0;
    rnd       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_shares", 32'(out_shares), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Every secret once, back to back, with latency checked.
    lat_chk = 1'b1;
    for (int s = 0; s < 16; s++) send(4'(s));
    drain();

    // Same secret under 100 fresh mask/randomness draws.
    for (int k = 0; k < 100; k++) send(4'h5);
    drain();

    // Full throughput: 16 beats in 16 cycles, 16 results out.
    n0 = n_out;
    c0 = cyc;
    for (int k = 0; k < 16; k++) send(4'($urandom));
    chk("tput_cycles", 32'(cyc - c0), 32'd16);
    repeat (2) @(posedge clk);
    #1;
    chk("tput_outputs", 32'(n_out - n0), 32'd16);
    drain();

    // Back-pressure: output blocked for 5 cycles while 8 beats are offered.
    lat_chk   = 1'b0;
    n0        = n_out;
    i0        = n_in;
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) send(4'($urandom));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_accepted", 32'(n_in - i0), 32'd2);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 32'(n_out - n0), 32'd8);

    // Reset with two beats in flight discards them.
    send(4'($urandom));
    send(4'($urandom));
    n0  = n_out;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_shares", 32'(out_shares), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_out", 32'(n_out - n0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
